dmem_access_unit: RTL
=====================

Name: dmem_access_unit

Overview:
- MEM-stage load/store unit between the 5-stage core and the DM AXI-style AR/R/AW/W channels.
- Replaces the fixed always-valid wiring with real handshaking. Accepts one access at a time from the pipeline and holds it in an FSM until every channel handshake completes.
- Generates byte strobes for SB/SH/SW and extracts/sign-extends LB/LH/LW/LBU/LHU from a wide memory line.
- Line width and address width are parametrised.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, core data width; fixed at 32 for RV32.
- LINE_W, 128, memory line width in bits; power of two, at least DATA_W.
- OFF_W, $clog2(LINE_W/8), derived byte-offset width within a line; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- req_valid  in  1  pipeline presents an access
- req_ready  out  1  unit idle, will accept this cycle
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32 funct3 of load/store
- req_addr  in  ADDR_W  effective address
- req_wdata  in  DATA_W  store data (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load result; 0 for stores/errors
- resp_err  out  1  misaligned or illegal funct3, qualified by resp_valid
- ARADDR  out  ADDR_W  line-aligned read address
- ARVALID  out  1  read address valid
- ARREADY  in  1  read address ready
- RDATA  in  LINE_W  read line
- RVALID  in  1  read data valid
- RREADY  out  1  read data ready
- AWADDR  out  ADDR_W  line-aligned write address
- AWVALID  out  1  write address valid
- AWREADY  in  1  write address ready
- WDATA  out  LINE_W  write data, lane-shifted
- WSTRB  out  LINE_W/8  byte strobes
- WVALID  out  1  write data valid
- WREADY  in  1  write data ready

Behaviour:
- Reset: state IDLE. All VALID/READY outputs 0, resp_valid 0, resp_err 0, resp_rdata 0, address/WDATA/WSTRB 0, internal aw_done/w_done 0.
- Reset mid-transaction aborts immediately: all valids drop, no resp_valid, return to IDLE.
- req_ready = (state==IDLE), combinational from state.
- Accept when req_valid && req_ready. Latch we, funct3, addr, wdata. Offset off = addr[OFF_W-1:0].
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Illegal or misaligned access: state ERR, then resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, then IDLE. No bus activity.
- Load path:
  - RD_A: ARVALID=1, ARADDR={addr[ADDR_W-1:OFF_W],0}. ARVALID and ARADDR stay stable until ARREADY. On handshake go to RD_D.
  - RD_D: RREADY=1. On RVALID, capture RDATA>>(off*8), apply extension per funct3, go to RESP.
  - ARREADY and RVALID arriving in the same cycle as entry to RD_A are handled: best-case latency is accept → resp_valid in 3 cycles.
- Store path:
  - WR: AWVALID=!aw_done, WVALID=!w_done. AWADDR is line-aligned.
  - WSTRB = base mask (SB 0x1, SH 0x3, SW 0xF) << off. WDATA = zero-extended wdata << off*8.
  - AW and W handshakes are independent; each sets its done flag and drops its valid the next cycle.
  - Both done, or both accepted in the same cycle → RESP.
  - Best-case latency is accept → resp_valid in 2 cycles.
- RESP: resp_valid=1 for exactly one cycle, resp_err=0, then IDLE. resp_rdata holds until the next response.
- New request acceptance is not possible in RESP; back-to-back throughput is at most one access per 3 (store) / 4 (load) cycles.
- Core holds req_* stable and stalls while req_ready=0 or until resp_valid.
- Spurious RVALID outside RD_D is ignored, since RREADY=0.
- WSTRB and WDATA are 0 outside WR.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum {IDLE, RD_A, RD_D, WR, ERR, RESP}.
  - Base strobe constants.
- One combinational sub-module, dmem_lane_align, parametrised by LINE_W:
  - Inputs: off, funct3, wdata, rline.
  - Outputs: wstrb, wline, load_ext, misaligned, illegal.
- The FSM and channel flags stay in dmem_access_unit.

Test Plan:
- LW addr 0x0000_1008, ARREADY=1, RVALID next cycle, RDATA word2=0x8765_4321 → ARADDR=0x0000_1000, resp_rdata=0x8765_4321, resp_valid 3 cycles after accept.
- LB addr 0x0000_100D with byte13=0x80 → resp_rdata=0xFFFF_FF80. The same access as LBU → 0x0000_0080.
- SH addr 0x0000_2006, wdata 0x0000_BEEF, AWREADY low 3 cycles, WREADY=1 immediately → WSTRB=0x00C0, WDATA[63:48]=0xBEEF, WVALID drops after 1 cycle, AWVALID held 4 cycles, a single resp_valid.
- SW addr 0x0000_3002 → resp_err=1, resp_rdata=0, no AWVALID/WVALID ever asserted. Load funct3=011 → resp_err=1, no ARVALID.
- Load with ARVALID asserted and ARREADY=0, then rst pulsed → ARVALID=0 immediately, req_ready=1 after reset, no resp_valid.
- Two back-to-back SB to 0x0F and 0x00 → WSTRB 0x8000 then 0x0001, req_ready low during each, exactly two resp_valid pulses.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the MEM-stage load/store unit: funct3 encodings,
// FSM state codes and the per-size base byte strobes.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t RD_A = 3'd1;
  localparam state_t RD_D = 3'd2;
  localparam state_t WR   = 3'd3;
  localparam state_t ERR  = 3'd4;
  localparam state_t RESP = 3'd5;

  localparam logic [3:0] STRB_BYTE = 4'h1;
  localparam logic [3:0] STRB_HALF = 4'h3;
  localparam logic [3:0] STRB_WORD = 4'hF;

  // Access size is carried by funct3[1:0]; the sign bit funct3[2] does not matter here.
  function automatic logic [3:0] base_strb(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   base_strb = STRB_BYTE;
      2'b01:   base_strb = STRB_HALF;
      default: base_strb = STRB_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a 32-bit core word and a LINE_W-bit memory line,
// plus alignment / funct3 legality classification of an access.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int LINE_W = 128,
  localparam int OFF_W  = $clog2(LINE_W/8)
) (
  input  logic [OFF_W-1:0]    off,
  input  logic                we,
  input  logic [2:0]          funct3,
  input  logic [31:0]         wdata,
  input  logic [LINE_W-1:0]   rline,
  output logic [LINE_W/8-1:0] wstrb,
  output logic [LINE_W-1:0]   wline,
  output logic [31:0]         load_ext,
  output logic                misaligned,
  output logic                illegal
);

  localparam int STRB_N = LINE_W/8;

  logic [OFF_W+2:0] bit_sh;
  logic [31:0]      rword;

  assign bit_sh = {off, 3'b000};
  assign wstrb  = STRB_N'(base_strb(funct3)) << off;
  assign wline  = LINE_W'(wdata) << bit_sh;
  assign rword  = 32'(rline >> bit_sh);

  always_comb begin
    case (funct3)
      F3_B:    load_ext = {{24{rword[7]}}, rword[7:0]};
      F3_H:    load_ext = {{16{rword[15]}}, rword[15:0]};
      F3_W:    load_ext = rword;
      F3_BU:   load_ext = {24'h0, rword[7:0]};
      F3_HU:   load_ext = {16'h0, rword[15:0]};
      default: load_ext = 32'h0;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Stores have no unsigned variants; loads reject 011, 110 and 111.
  assign illegal = we ? (funct3[2] || (funct3[1:0] == 2'b11))
                      : ((funct3[1:0] == 2'b11) || (funct3 == 3'b110));

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit: holds one access at a time and drives the
// AR/R or AW/W handshakes to completion before pulsing resp_valid.
//
// state | meaning
// IDLE  | req_ready high, waiting for an access
// RD_A  | read address offered on AR
// RD_D  | waiting for the read line on R
// WR    | AW and W offered independently until both accepted
// ERR   | illegal funct3 or misaligned, no bus activity
// RESP  | one-cycle completion pulse
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int LINE_W = 128,
  localparam int OFF_W  = $clog2(LINE_W/8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [LINE_W-1:0]   RDATA,
  input  logic                RVALID,
  output logic                RREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [LINE_W-1:0]   WDATA,
  output logic [LINE_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY
);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                sel_idle;
  logic [OFF_W-1:0]    al_off;
  logic                al_we;
  logic [2:0]          al_f3;
  logic [LINE_W/8-1:0] al_wstrb;
  logic [LINE_W-1:0]   al_wline;
  logic [31:0]         al_load;
  logic                al_misaligned;
  logic                al_illegal;
  logic                aw_fire, w_fire;
  logic [ADDR_W-1:0]   line_addr;

  // While idle the aligner classifies the incoming request; afterwards it works on the latched one.
  assign sel_idle = (state_q == IDLE);
  assign al_off   = sel_idle ? req_addr[OFF_W-1:0] : addr_q[OFF_W-1:0];
  assign al_we    = sel_idle ? req_we : we_q;
  assign al_f3    = sel_idle ? req_funct3 : funct3_q;

  dmem_lane_align #(
    .LINE_W (LINE_W)
  ) u_lane_align (
    .off        (al_off),
    .we         (al_we),
    .funct3     (al_f3),
    .wdata      (wdata_q),
    .rline      (RDATA),
    .wstrb      (al_wstrb),
    .wline      (al_wline),
    .load_ext   (al_load),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          funct3_d  = req_funct3;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (al_misaligned || al_illegal) state_d = ERR;
          else if (req_we)                 state_d = WR;
          else                             state_d = RD_A;
        end
      end
      RD_A: begin
        if (ARREADY) state_d = RD_D;
      end
      RD_D: begin
        if (RVALID) begin
          rdata_d = DATA_W'(al_load);
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      WR: begin
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      ERR: begin
        rdata_d = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign line_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = rdata_q;

  assign ARADDR  = line_addr;
  assign ARVALID = (state_q == RD_A);
  assign RREADY  = (state_q == RD_D);

  assign AWADDR  = line_addr;
  assign AWVALID = (state_q == WR) && !aw_done_q;
  assign WVALID  = (state_q == WR) && !w_done_q;
  assign WSTRB   = (state_q == WR) ? al_wstrb : '0;
  assign WDATA   = (state_q == WR) ? al_wline : '0;

endmodule
